// File: rtl/cache_sa.sv
// cache_sa: N-way set-associative, write-back, write-allocate cache with true LRU.
// Defining CACHE_SA_PERF_EN builds the hit/miss counters; otherwise they read 0.
module cache_sa #(
  parameter int WAYS   = 2,
  parameter int SETS   = 4,
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic [31:0]       proc_rdata,
  output logic              proc_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - 2 - IW;
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_ALLOC} state_t;

  // Handshake: the processor holds proc_read/proc_write (and address/data) until
  // proc_stall is low; mem_read/mem_write stay high until a one-cycle mem_ready.
  state_t                    state_q, state_d;
  logic [WAYS-1:0][SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TW-1:0]             tag_q  [WAYS][SETS];
  logic [TW-1:0]             tag_d  [WAYS][SETS];
  logic [127:0]              line_q [WAYS][SETS];
  logic [127:0]              line_d [WAYS][SETS];
  logic [AW-1:0]             age_q  [WAYS][SETS];
  logic [AW-1:0]             age_d  [WAYS][SETS];
  logic [AW-1:0]             victim_q, victim_d;
  logic                      mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_W-3:0]         mem_addr_q, mem_addr_d;
  logic [127:0]              mem_wdata_q, mem_wdata_d;

  logic          req, hit, vfound, hit_done, miss_det;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [1:0]    wsel;
  logic [AW-1:0] hit_way, vic_way, vmax;
  logic [127:0]  hit_line;

  assign req  = proc_read | proc_write;
  assign idx  = proc_addr[IW+1:2];
  assign tag  = proc_addr[ADDR_W-1:IW+2];
  assign wsel = proc_addr[1:0];

  always_comb begin : lookup
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
    // Victim: lowest invalid way, else the oldest way.
    vfound  = 1'b0;
    vic_way = '0;
    vmax    = age_q[0][idx];
    for (int w = 0; w < WAYS; w++) begin
      if (!vfound && !valid_q[w][idx]) begin
        vfound  = 1'b1;
        vic_way = AW'(w);
      end
    end
    if (!vfound) begin
      for (int w = 1; w < WAYS; w++) begin
        if (age_q[w][idx] > vmax) begin
          vmax    = age_q[w][idx];
          vic_way = AW'(w);
        end
      end
    end
  end

  assign hit_line   = line_q[hit_way][idx];
  assign hit_done   = (state_q == S_IDLE) && req && hit;
  assign miss_det   = (state_q == S_IDLE) && req && !hit;
  assign proc_stall = req && !hit_done;
  assign proc_rdata = (hit_done && proc_read && !proc_write) ? hit_line[{wsel, 5'd0} +: 32] : '0;

  always_comb begin : next_state
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    line_d      = line_q;
    age_d       = age_q;
    victim_d    = victim_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (hit_done) begin
          if (proc_write) begin
            line_d[hit_way][idx][{wsel, 5'd0} +: 32] = proc_wdata;
            dirty_d[hit_way][idx] = 1'b1;
          end
          if (WAYS > 1) begin
            for (int w = 0; w < WAYS; w++) begin
              if (AW'(w) == hit_way) age_d[w][idx] = '0;
              else if (age_q[w][idx] < age_q[hit_way][idx]) age_d[w][idx] = age_q[w][idx] + 1'b1;
            end
          end
        end else if (miss_det) begin
          victim_d = vic_way;
          if (valid_q[vic_way][idx] && dirty_q[vic_way][idx]) begin
            state_d     = S_WB;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[vic_way][idx], idx};
            mem_wdata_d = line_q[vic_way][idx];
          end else begin
            state_d    = S_ALLOC;
            mem_read_d = 1'b1;
            mem_addr_d = {tag, idx};
          end
        end
      end
      S_WB: begin
        if (mem_ready) begin
          state_d     = S_ALLOC;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = {tag, idx};
          mem_wdata_d = '0;
        end
      end
      S_ALLOC: begin
        if (mem_ready) begin
          line_d[victim_q][idx]  = mem_rdata;
          tag_d[victim_q][idx]   = tag;
          valid_d[victim_q][idx] = 1'b1;
          dirty_d[victim_q][idx] = 1'b0;
          state_d    = S_IDLE;
          mem_read_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      victim_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          tag_q[w][s]  <= '0;
          line_q[w][s] <= '0;
          age_q[w][s]  <= AW'(w);
        end
      end
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      tag_q       <= tag_d;
      line_q      <= line_d;
      age_q       <= age_d;
      victim_q    <= victim_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef CACHE_SA_PERF_EN
  // missed_q marks the re-evaluation hit that closes a miss, so it is not counted.
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        missed_q, missed_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    missed_d   = missed_q;
    if (hit_done) begin
      if (!missed_q) hit_cnt_d = hit_cnt_q + 32'd1;
      missed_d = 1'b0;
    end
    if (miss_det) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
      missed_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      missed_q   <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      missed_q   <= missed_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_cache_sa.sv
// Directed testbench for cache_sa (WAYS=2, SETS=4, ADDR_W=30).
module tb_cache_sa;
  logic         clk = 1'b0;
  logic         proc_reset, proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata, proc_rdata;
  logic         proc_stall, mem_read, mem_write, mem_ready;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic [31:0]  hit_cnt, miss_cnt;

  int errors = 0;
  int checks = 0;

  int           wr_seen, rd_seen, early_rd, both_hi, stalls_obs;
  logic [27:0]  wr_addr_obs, rd_addr_obs;
  logic [127:0] wr_data_obs;
  logic         rd_at_done;
  logic [31:0]  rdata_obs;
  logic [31:0]  exp_q[$];

  localparam logic [127:0] L1 = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
  localparam logic [127:0] L2 = {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000};
  localparam logic [127:0] L3 = {32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
  localparam logic [127:0] L4 = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
  localparam logic [127:0] L5 = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
  localparam logic [127:0] L6 = {32'h6666_0003, 32'h6666_0002, 32'h6666_0001, 32'h6666_0000};
  localparam logic [127:0] L7 = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};

  cache_sa #(.WAYS(2), .SETS(4), .ADDR_W(30)) dut (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
    .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // One processor access; the memory answers each request after lat cycles.
  // Called at a negedge, returns at a negedge with the request dropped.
  task automatic access(input logic wr, input logic [29:0] a, input logic [31:0] wd,
                        input int lat, input logic [127:0] line);
    int   busy;
    logic wb_acked, done;
    busy = 0; wb_acked = 1'b0; done = 1'b0;
    wr_seen = 0; rd_seen = 0; early_rd = 0; both_hi = 0; stalls_obs = 0;
    rd_at_done = 1'b0; rdata_obs = '0;
    proc_write = wr; proc_read = !wr; proc_addr = a; proc_wdata = wd;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      #1;
      if (!proc_stall) begin
        rdata_obs  = proc_rdata;
        rd_at_done = mem_read;
        done       = 1'b1;
      end else begin
        stalls_obs++;
        if (mem_read && mem_write) both_hi++;
        if (mem_write) begin
          wr_seen++; wr_addr_obs = mem_addr; wr_data_obs = mem_wdata;
        end
        if (mem_read) begin
          rd_seen++; rd_addr_obs = mem_addr;
          if (wr_seen > 0 && !wb_acked) early_rd++;
        end
        if (mem_read || mem_write) begin
          busy++;
          if (busy == lat) begin
            mem_ready = 1'b1; mem_rdata = line; busy = 0;
            if (mem_write) wb_acked = 1'b1;
          end
        end
      end
      @(negedge clk);
      mem_ready = 1'b0;
    end
    proc_read = 1'b0; proc_write = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout addr=%h never completed within 200 cycles", a);
    end
  endtask

  task automatic test_reset();
    proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0;
    proc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got=%b exp=0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
    checks++; if (mem_addr !== 28'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 128'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (proc_rdata !== 32'h0) begin errors++; $display("FAIL reset_proc_rdata got=%h exp=0", proc_rdata); end
    checks++; if (proc_stall !== 1'b0) begin errors++; $display("FAIL reset_idle_stall got=%b exp=0", proc_stall); end
    checks++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_counters got hit=%0d miss=%0d exp 0/0", hit_cnt, miss_cnt);
    end
    proc_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_read();
    logic [31:0] exp;
    exp_q.push_back(32'hAAAA_AAAA);
    exp_q.push_back(32'hBBBB_BBBB);
    access(1'b0, 30'h10, '0, 3, L1);
    exp = exp_q.pop_front();
    checks++; if (rdata_obs !== exp) begin errors++; $display("FAIL miss_rdata got=%h exp=%h", rdata_obs, exp); end
    checks++; if (rd_addr_obs !== 28'h4 || rd_seen == 0) begin errors++; $display("FAIL miss_mem_addr got=%h reads=%0d exp=4", rd_addr_obs, rd_seen); end
    checks++; if (wr_seen !== 0) begin errors++; $display("FAIL miss_no_write got=%0d exp=0", wr_seen); end
    checks++; if (stalls_obs !== 4) begin errors++; $display("FAIL miss_stall got=%0d exp=4", stalls_obs); end
    access(1'b0, 30'h11, '0, 3, L1);
    exp = exp_q.pop_front();
    checks++; if (rdata_obs !== exp) begin errors++; $display("FAIL hit_rdata got=%h exp=%h", rdata_obs, exp); end
    checks++; if (stalls_obs !== 0) begin errors++; $display("FAIL hit_stall got=%0d exp=0", stalls_obs); end
  endtask

  task automatic test_lru();
    access(1'b0, 30'h20, '0, 3, L2);
    checks++; if (rdata_obs !== 32'h2222_0000) begin errors++; $display("FAIL lru_fill2 got=%h exp=22220000", rdata_obs); end
    access(1'b0, 30'h10, '0, 3, L1);
    checks++; if (stalls_obs !== 0) begin errors++; $display("FAIL lru_touch1_stall got=%0d exp=0", stalls_obs); end
    access(1'b0, 30'h30, '0, 3, L3);
    checks++; if (wr_seen !== 0 || rd_addr_obs !== 28'hC) begin
      errors++; $display("FAIL lru_fill3 got writes=%0d addr=%h exp 0/c", wr_seen, rd_addr_obs);
    end
    access(1'b0, 30'h10, '0, 3, L1);
    checks++; if (stalls_obs !== 0 || rdata_obs !== 32'hAAAA_AAAA) begin
      errors++; $display("FAIL lru_keep1 got stall=%0d data=%h exp 0/aaaaaaaa", stalls_obs, rdata_obs);
    end
    access(1'b0, 30'h20, '0, 3, L2);
    checks++; if (stalls_obs !== 4) begin errors++; $display("FAIL lru_evicted2 got stall=%0d exp=4", stalls_obs); end
  endtask

  task automatic test_writeback();
    logic [127:0] exp_line;
    exp_line = L4;
    exp_line[95:64] = 32'hDEAD_BEEF;
    access(1'b0, 30'h14, '0, 2, L4);
    access(1'b1, 30'h16, 32'hDEAD_BEEF, 2, L4);
    checks++; if (stalls_obs !== 0) begin errors++; $display("FAIL wb_write_hit_stall got=%0d exp=0", stalls_obs); end
    access(1'b0, 30'h24, '0, 2, L5);
    checks++; if (wr_seen !== 0) begin errors++; $display("FAIL wb_clean_fill got writes=%0d exp=0", wr_seen); end
    access(1'b0, 30'h34, '0, 2, L6);
    checks++; if (wr_seen == 0 || wr_addr_obs !== 28'h5) begin
      errors++; $display("FAIL wb_addr got writes=%0d addr=%h exp addr=5", wr_seen, wr_addr_obs);
    end
    checks++; if (wr_data_obs !== exp_line) begin errors++; $display("FAIL wb_data got=%h exp=%h", wr_data_obs, exp_line); end
    checks++; if (early_rd !== 0 || both_hi !== 0) begin
      errors++; $display("FAIL wb_order got early_reads=%0d overlap=%0d exp 0/0", early_rd, both_hi);
    end
    checks++; if (rd_addr_obs !== 28'hD || stalls_obs !== 5) begin
      errors++; $display("FAIL wb_alloc got addr=%h stall=%0d exp d/5", rd_addr_obs, stalls_obs);
    end
    checks++; if (rdata_obs !== 32'h6666_0000) begin errors++; $display("FAIL wb_rdata got=%h exp=66660000", rdata_obs); end
  endtask

  task automatic test_latency();
    access(1'b0, 30'h18, '0, 7, L7);
    checks++; if (stalls_obs !== 8) begin errors++; $display("FAIL lat7_stall got=%0d exp=8", stalls_obs); end
    checks++; if (rd_at_done !== 1'b0) begin errors++; $display("FAIL lat7_read_drop got=%b exp=0", rd_at_done); end
    checks++; if (rdata_obs !== 32'h7777_0000) begin errors++; $display("FAIL lat7_rdata got=%h exp=77770000", rdata_obs); end
  endtask

  task automatic test_reset_mid_miss();
    logic seen;
    seen = 1'b0;
    proc_read = 1'b1; proc_addr = 30'h1C;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (mem_read) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_alloc_reach got mem_read=0 exp=1 within 20 cycles"); end
    proc_reset = 1'b1;
    #1;
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 28'h0) begin
      errors++; $display("FAIL rst_mid_outputs got rd=%b wr=%b addr=%h exp 0/0/0", mem_read, mem_write, mem_addr);
    end
    @(negedge clk);
    proc_reset = 1'b0; proc_read = 1'b0;
    @(negedge clk);
    access(1'b0, 30'h1C, '0, 2, L1);
    checks++; if (stalls_obs !== 3 || rd_seen == 0) begin
      errors++; $display("FAIL rst_refetch got stall=%0d reads=%0d exp 3/>0", stalls_obs, rd_seen);
    end
    access(1'b0, 30'h10, '0, 2, L1);
    checks++; if (stalls_obs !== 3) begin errors++; $display("FAIL rst_valid_cleared got stall=%0d exp=3", stalls_obs); end
  endtask

  task automatic test_perf();
    logic [31:0] exp_hit, exp_miss;
`ifdef CACHE_SA_PERF_EN
    exp_hit = 32'd5; exp_miss = 32'd3;
`else
    exp_hit = 32'd0; exp_miss = 32'd0;
`endif
    proc_reset = 1'b1;
    @(negedge clk);
    proc_reset = 1'b0;
    @(negedge clk);
    access(1'b0, 30'h10, '0, 2, L1);
    access(1'b0, 30'h24, '0, 2, L2);
    access(1'b0, 30'h38, '0, 2, L3);
    access(1'b0, 30'h11, '0, 2, L1);
    access(1'b0, 30'h12, '0, 2, L1);
    access(1'b0, 30'h25, '0, 2, L2);
    access(1'b1, 30'h39, 32'h1234_5678, 2, L3);
    access(1'b0, 30'h10, '0, 2, L1);
    checks++; if (hit_cnt !== exp_hit) begin errors++; $display("FAIL perf_hit_cnt got=%0d exp=%0d", hit_cnt, exp_hit); end
    checks++; if (miss_cnt !== exp_miss) begin errors++; $display("FAIL perf_miss_cnt got=%0d exp=%0d", miss_cnt, exp_miss); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_lru();
    test_writeback();
    test_latency();
    test_reset_mid_miss();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
